ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: the sending side of the keyboard link, complementing the existing PS/2 keyboard receiver. It sends single command bytes to the keyboard, such as 0xED (set LEDs) or 0xFF (reset). It implements the full host-request sequence: clock inhibit, start bit, 8 data bits LSB-first, odd parity, stop bit, device ACK. It drives the shared open-drain PS/2 lines alongside the receiver, and asserts `rx_inhibit` so the receiver ignores bus activity while a transmit frame is in progress.

---
 rtl/ps2_host_tx_if.sv | 18 +
 rtl/ps2_host_tx.sv | 119 +++++++++++
 tb/tb_ps2_host_tx.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: byte handshake plus the open-drain PS/2 clock/data line group
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  modport master (
    output tx_data, tx_valid, ps2_clk_in, ps2_dat_in,
    input  tx_ready, ps2_clk_oe, ps2_dat_oe
  );
  modport slave (
    input  tx_data, tx_valid, ps2_clk_in, ps2_dat_in,
    output tx_ready, ps2_clk_oe, ps2_dat_oe
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command byte transmitter with device ACK check
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 1500,
  parameter int TIMEOUT_CYCLES = 30000
) (
  input  logic             sys_clock,
  input  logic             reset_n,
  ps2_host_tx_if.slave     bus,
  output logic             busy,
  output logic             rx_inhibit,
  output logic             done,
  output logic             error
);
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, START, SHIFT, ACK, WAIT_RELEASE} state_t;
  localparam logic [15:0] INH_LAST = 16'(INHIBIT_CYCLES - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  state_t      state_q, state_d;
  logic [2:0]  clk_s_q, dat_s_q;
  logic [9:0]  shift_q, shift_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] timer_q, timer_d;
  logic        clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;
  logic        ready_q, ready_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic        fall, accept, timed, shift_ev;
  assign fall       = clk_s_q[2] & ~clk_s_q[1];
  assign accept     = bus.tx_valid & ready_q;
  assign timed      = state_q inside {START, SHIFT, ACK, WAIT_RELEASE};
  assign bus.tx_ready   = ready_q;
  assign bus.ps2_clk_oe = clk_oe_q;
  assign bus.ps2_dat_oe = dat_oe_q;
  assign busy       = busy_q;
  assign rx_inhibit = busy_q;
  assign done       = done_q;
  assign error      = err_q;
  // State, datapath and registered outputs; synchronizers idle high like the bus
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      clk_s_q   <= '1;
      dat_s_q   <= '1;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      timer_q   <= '0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_s_q   <= {clk_s_q[1:0], bus.ps2_clk_in};
      dat_s_q   <= {dat_s_q[1:0], bus.ps2_dat_in};
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      timer_q   <= timer_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end
  // Next state: frame sequencing, bit shifting on device clock falls, timeout abort
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    shift_ev  = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        state_d   = INHIBIT;
        shift_d   = {1'b1, ~^bus.tx_data, bus.tx_data};
        bit_cnt_d = '0;
      end
      INHIBIT: state_d = (timer_q == INH_LAST) ? REQ : INHIBIT;
      REQ: state_d = START;
      START: if (fall) begin
        shift_ev = 1'b1;
        state_d  = SHIFT;
      end
      SHIFT: if (fall) begin
        shift_ev = 1'b1;
        state_d  = (bit_cnt_q == 4'd9) ? ACK : SHIFT;
      end
      ACK: if (fall) begin
        state_d = dat_s_q[1] ? IDLE : WAIT_RELEASE;
        err_d   = dat_s_q[1];
      end
      WAIT_RELEASE: if (&{clk_s_q[2:1], dat_s_q[2:1]}) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (shift_ev) begin
      shift_d   = {1'b0, shift_q[9:1]};
      bit_cnt_d = bit_cnt_q + 4'd1;
    end
    if (timed && !fall && state_d == state_q && timer_q == TMO_LAST) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
    timer_d = (state_d != state_q || (timed && fall)) ? '0 :
              (state_q == IDLE || state_q == REQ) ? timer_q : timer_q + 16'd1;
  end
  // Outputs derived from the next state so every output is a flop
  always_comb begin
    clk_oe_d = state_d == INHIBIT || state_d == REQ;
    dat_oe_d = (state_d == REQ || state_d == START) ? 1'b1 :
               shift_ev ? ~shift_q[0] :
               (state_d == SHIFT) ? dat_oe_q : 1'b0;
    busy_d   = state_d != IDLE;
    ready_d  = state_d == IDLE && !done_d && !err_d;
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: device-model bench with a scoreboard of expected data-line drive levels
module tb_ps2_host_tx;
  localparam int IC = 20;
  localparam int TC = 400;
  localparam int H  = 40;
  logic clk = 1'b0, rst_n = 1'b0, dev_clk = 1'b1, dev_dat = 1'b1;
  logic busy, rx_inhibit, done, error;
  int n_chk = 0, n_fail = 0, done_cnt = 0, err_cnt = 0;
  logic exp_q[$];
  ps2_host_tx_if bus();
  assign bus.ps2_clk_in = ~bus.ps2_clk_oe & dev_clk;
  assign bus.ps2_dat_in = ~bus.ps2_dat_oe & dev_dat;
  ps2_host_tx #(.INHIBIT_CYCLES(IC), .TIMEOUT_CYCLES(TC)) dut (
    .sys_clock(clk), .reset_n(rst_n), .bus(bus),
    .busy(busy), .rx_inhibit(rx_inhibit), .done(done), .error(error)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  always @(negedge clk) if (rst_n) begin
    chk("rx_inhibit_eq_busy", rx_inhibit, busy);
    chk("done_error_excl", done & error, 0);
    done_cnt += int'(done);
    err_cnt  += int'(error);
  end
  task automatic push_byte(logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(!b[i]);
      ones += int'(b[i]);
    end
    exp_q.push_back((ones % 2) != 0);
    exp_q.push_back(1'b0);
  endtask
  task automatic start_tx(logic [7:0] b, bit hold);
    int g = 0;
    bus.tx_data = b;
    bus.tx_valid = 1'b1;
    while (!bus.tx_ready && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk("accept_ready", bus.tx_ready, 1);
    push_byte(b);
    @(negedge clk);
    if (!hold) bus.tx_valid = 1'b0;
    chk("inhibit_clk_oe", bus.ps2_clk_oe, 1);
    chk("inhibit_ready", bus.tx_ready, 0);
  endtask
  task automatic wait_start();
    int inh = 0, req = 0, g = 0;
    while (bus.ps2_clk_oe && g < IC + 50) begin
      if (bus.ps2_dat_oe) req++; else inh++;
      @(negedge clk);
      g++;
    end
    chk("inhibit_cycles", inh, IC);
    chk("req_cycles", req, 1);
    chk("start_clk_oe", bus.ps2_clk_oe, 0);
    chk("start_dat_oe", bus.ps2_dat_oe, 1);
  endtask
  task automatic dev_frame(int nfall, bit ack);
    for (int k = 1; k <= nfall; k++) begin
      if (k == 11 && ack) dev_dat = 1'b0;
      repeat (H / 2) @(negedge clk);
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      if (k <= 10) begin
        if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
        else chk($sformatf("bit_fall%0d", k), bus.ps2_dat_oe, exp_q.pop_front());
      end
      dev_clk = 1'b1;
      repeat (H / 2) @(negedge clk);
    end
    dev_dat = 1'b1;
  endtask
  task automatic wait_end(bit exp_done, int d0, int e0);
    int g = 0;
    while (done_cnt + err_cnt == d0 + e0 && !(done | error) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk("end_seen", (done_cnt + err_cnt != d0 + e0) || done || error, 1);
    @(negedge clk);
    chk("end_ready", bus.tx_ready, 1);
    chk("end_done_low", done, 0);
    chk("end_clk_oe", bus.ps2_clk_oe, 0);
    chk("end_dat_oe", bus.ps2_dat_oe, 0);
    chk("end_busy", busy, 0);
    chk("done_pulses", done_cnt - d0, exp_done);
    chk("err_pulses", err_cnt - e0, !exp_done);
  endtask
  task automatic send(logic [7:0] b, bit ack);
    int d0 = done_cnt, e0 = err_cnt;
    start_tx(b, 1'b0);
    wait_start();
    dev_frame(11, ack);
    wait_end(ack, d0, e0);
    chk("sb_drained", exp_q.size(), 0);
  endtask
  initial begin
    int d0, e0, g;
    bus.tx_valid = 1'b0;
    bus.tx_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.tx_ready, 1);
    chk("rst_clk_oe", bus.ps2_clk_oe, 0);
    chk("rst_dat_oe", bus.ps2_dat_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'hED, 1'b1);
    send(8'h01, 1'b1);
    send(8'hFF, 1'b1);
    send(8'hA5, 1'b0);
    exp_q.delete();
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'h55, 1'b0);
    wait_start();
    g = 0;
    while (!error && g < TC + 50) begin
      @(negedge clk);
      g++;
    end
    chk("timeout_cycles", g, TC);
    chk("timeout_clk_oe", bus.ps2_clk_oe, 0);
    chk("timeout_dat_oe", bus.ps2_dat_oe, 0);
    @(negedge clk);
    chk("timeout_ready", bus.tx_ready, 1);
    chk("timeout_done_pulses", done_cnt - d0, 0);
    exp_q.delete();
    start_tx(8'h17, 1'b0);
    wait_start();
    dev_frame(4, 1'b0);
    chk("pre_reset_dat_oe", bus.ps2_dat_oe, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_dat_oe", bus.ps2_dat_oe, 0);
    chk("async_rst_clk_oe", bus.ps2_clk_oe, 0);
    chk("async_rst_ready", bus.tx_ready, 1);
    chk("async_rst_busy", busy, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", bus.tx_ready, 1);
    send(8'hF4, 1'b1);
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'h96, 1'b1);
    bus.tx_data = 8'h3C;
    wait_start();
    dev_frame(11, 1'b1);
    wait_end(1'b1, d0, e0);
    chk("held_sb_drained", exp_q.size(), 0);
    chk("held_valid_still", bus.tx_valid, 1);
    send(8'h3C, 1'b1);
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
